// File: rtl/sat_shift.sv
// Arithmetic right shift followed by two's-complement saturation.
// Purely combinational; floor rounding comes from the arithmetic shift.
module sat_shift #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SH_W  = 5
) (
  input  logic signed [IN_W-1:0]  in_i,
  input  logic        [SH_W-1:0]  shift_i,
  output logic signed [OUT_W-1:0] out_o
);

  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // Shift, then clamp when the bits above the output sign are not a pure sign extension.
  always_comb begin
    shifted = in_i >>> shift_i;
    if ((shifted[IN_W-1:OUT_W-1] == '0) || (shifted[IN_W-1:OUT_W-1] == '1)) begin
      out_o = shifted[OUT_W-1:0];
    end else if (shifted[IN_W-1]) begin
      out_o = SAT_MIN;
    end else begin
      out_o = SAT_MAX;
    end
  end

endmodule

// File: rtl/axis_boxcar_decimator.sv
// Accumulate-and-dump decimator: sums N samples, shifts right by S, saturates,
// and emits one sample per N accepted inputs on a registered AXI-Stream output.
module axis_boxcar_decimator #(
  parameter int unsigned AXIS_TDATA_WIDTH = 16,
  parameter int unsigned CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH+4:0]       cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int unsigned ACC_W = AXIS_TDATA_WIDTH + CNTR_WIDTH;

  logic signed [ACC_W-1:0]            acc_q, acc_d;
  logic        [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic        [CNTR_WIDTH-1:0]       n_q;
  logic        [4:0]                  s_q;
  logic        [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                               tvalid_q;

  logic                               accept;
  logic                               block_start;
  logic                               block_end;
  logic        [CNTR_WIDTH-1:0]       cfg_n_eff;
  logic        [4:0]                  cfg_s;
  logic        [CNTR_WIDTH-1:0]       n_cur;
  logic        [4:0]                  s_cur;
  logic signed [ACC_W-1:0]            sample_ext;
  logic signed [AXIS_TDATA_WIDTH-1:0] scaled;

  // Handshake, block boundary detection and next accumulator/counter values.
  // On a block-start accept the freshly latched N and S are used directly,
  // so N=1 closes the block on its first sample.
  always_comb begin
    s_axis_tready = ~tvalid_q | m_axis_tready;
    accept        = s_axis_tvalid & s_axis_tready;
    block_start   = (cnt_q == '0);
    cfg_n_eff     = (cfg_data[CNTR_WIDTH-1:0] == '0) ? CNTR_WIDTH'(1) : cfg_data[CNTR_WIDTH-1:0];
    cfg_s         = cfg_data[CNTR_WIDTH+4:CNTR_WIDTH];
    n_cur         = block_start ? cfg_n_eff : n_q;
    s_cur         = block_start ? cfg_s : s_q;
    sample_ext    = ACC_W'($signed(s_axis_tdata));
    acc_d         = block_start ? sample_ext : (acc_q + sample_ext);
    cnt_d         = cnt_q + CNTR_WIDTH'(1);
    block_end     = accept && (cnt_d == n_cur);
  end

  sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (AXIS_TDATA_WIDTH),
    .SH_W  (5)
  ) u_sat_shift (
    .in_i    (acc_d),
    .shift_i (s_cur),
    .out_o   (scaled)
  );

  // Accumulator, sample counter, latched config and registered output stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      n_q      <= CNTR_WIDTH'(1);
      s_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= acc_d;
        if (block_start) begin
          n_q <= cfg_n_eff;
          s_q <= cfg_s;
        end
        cnt_q <= block_end ? '0 : cnt_d;
      end
      if (block_end) begin
        tdata_q  <= scaled;
        tvalid_q <= 1'b1;
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    m_axis_tdata  = tdata_q;
    m_axis_tvalid = tvalid_q;
  end

endmodule
